// File: rtl/spi_sample_rx.sv
// SPI mode-0 slave receiver: deserializes bytes from asynchronous SCLK/MOSI/CS_n
// and writes them zero-extended into a DEPTH-word frame buffer with ready/ack handoff.
module spi_sample_rx #(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_SPI_Clk,
  input  logic          i_SPI_MOSI,
  input  logic          i_SPI_CS_n,
  input  logic          i_Frame_Ack,
  output logic [7:0]    o_RX_Byte,
  output logic          o_RX_DV,
  output logic          o_WE,
  output logic [AW-1:0] o_WADDR,
  output logic [15:0]   o_WDATA,
  output logic          o_Frame_Ready,
  output logic          o_Overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FULL
  } state_t;

  logic          sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic          cs_meta_q, cs_sync_q;
  logic          mosi_meta_q, mosi_sync_q;
  logic [1:0]    flush_q;
  logic          armed_q;
  state_t        state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    rx_byte_q;
  logic          rx_dv_q;
  logic          we_q;
  logic [15:0]   wdata_q;
  logic          ready_q;
  logic          ovr_q;

  logic          sclk_rise_d;
  logic [7:0]    byte_d;
  logic          byte_done_d;
  logic          last_addr_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      flush_q     <= '0;
    end else begin
      sclk_meta_q <= i_SPI_Clk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= i_SPI_CS_n;
      cs_sync_q   <= cs_meta_q;
      mosi_meta_q <= i_SPI_MOSI;
      mosi_sync_q <= mosi_meta_q;
      flush_q     <= {flush_q[0], 1'b1};
    end
  end

  always_comb begin
    sclk_rise_d = sclk_sync_q & ~sclk_prev_q;
    byte_d      = {shift_q[6:0], mosi_sync_q};
    byte_done_d = sclk_rise_d & ~cs_sync_q & (state_q != S_IDLE) & (bit_cnt_q == 3'd7);
    last_addr_d = (addr_q == AW'(DEPTH - 1));
  end

  // CS_n low at reset release must not open a window: the select is only armed
  // once a genuine high level has passed through the flushed synchronizer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      armed_q   <= 1'b0;
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      rx_byte_q <= '0;
      rx_dv_q   <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      ready_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_dv_q <= 1'b0;
      we_q    <= 1'b0;

      if (flush_q[1] && cs_sync_q) armed_q <= 1'b1;

      if (cs_sync_q || state_q == S_IDLE) begin
        bit_cnt_q <= '0;
      end else if (sclk_rise_d) begin
        shift_q   <= byte_d;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end

      if (byte_done_d) begin
        rx_byte_q <= byte_d;
        rx_dv_q   <= 1'b1;
      end

      if (we_q) addr_q <= addr_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (armed_q && !cs_sync_q) state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (we_q && last_addr_d) begin
            state_q <= S_FULL;
            ready_q <= 1'b1;
          end else if (cs_sync_q) begin
            state_q <= S_IDLE;
          end else if (byte_done_d) begin
            we_q    <= 1'b1;
            wdata_q <= {8'h00, byte_d};
          end
        end
        S_FULL: begin
          // The address has already wrapped to 0, so an ack coinciding with a
          // byte lets that byte land at address 0 as the first of a new frame.
          if (i_Frame_Ack) begin
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            addr_q  <= '0;
            state_q <= cs_sync_q ? S_IDLE : S_SHIFT;
            if (byte_done_d) begin
              we_q    <= 1'b1;
              wdata_q <= {8'h00, byte_d};
            end
          end else if (byte_done_d) begin
            ovr_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_RX_Byte     = rx_byte_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_WE          = we_q;
  assign o_WADDR       = addr_q;
  assign o_WDATA       = wdata_q;
  assign o_Frame_Ready = ready_q;
  assign o_Overrun     = ovr_q;

endmodule

// File: tb/tb_spi_sample_rx.sv
// Randomized scoreboard bench for spi_sample_rx: a frame-level model predicts
// each completed byte and its write; a monitor compares whenever a byte emerges.
`timescale 1ns/1ps
module tb_spi_sample_rx;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          sclk = 1'b0;
  logic          mosi = 1'b0;
  logic          cs_n = 1'b1;
  logic          ack = 1'b0;
  logic [7:0]    rx_byte;
  logic          rx_dv;
  logic          we;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;
  logic          ready;
  logic          ovr;

  spi_sample_rx #(.DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .i_SPI_Clk    (sclk),
    .i_SPI_MOSI   (mosi),
    .i_SPI_CS_n   (cs_n),
    .i_Frame_Ack  (ack),
    .o_RX_Byte    (rx_byte),
    .o_RX_DV      (rx_dv),
    .o_WE         (we),
    .o_WADDR      (waddr),
    .o_WDATA      (wdata),
    .o_Frame_Ready(ready),
    .o_Overrun    (ovr)
  );

  always #31 CLK = ~CLK;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    b;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned ph = 10;
  int unsigned m_addr = 0;
  bit          m_full = 0;
  bit          m_ovr = 0;
  bit          chk_ready_next = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Frame-buffer model: DEPTH writes fill the frame; bytes beyond that are overruns.
  function automatic void model_byte(logic [7:0] b, bit acked);
    exp_t x;
    if (acked && m_full) begin
      m_full = 0;
      m_ovr  = 0;
      m_addr = 0;
    end
    if (m_full) begin
      x = '{we: 1'b0, addr: '0, b: b};
      m_ovr = 1;
    end else begin
      x = '{we: 1'b1, addr: AW'(m_addr), b: b};
      m_addr = (m_addr + 1) % DEPTH;
      if (m_addr == 0) m_full = 1;
    end
    exp_q.push_back(x);
  endfunction

  task automatic wait_clk(int n);
    repeat (n) @(posedge CLK);
    #(ph);
  endtask

  task automatic send_bits(logic [7:0] b, int nbits, bit ack_on_last);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      wait_clk(2);
      sclk = 1'b1;
      if (ack_on_last && i == nbits - 1) begin
        // two sync stages plus the edge register: completion is processed on the 3rd edge
        @(posedge CLK);
        @(posedge CLK);
        #1 ack = 1'b1;
        @(posedge CLK);
        #1 ack = 1'b0;
        wait_clk(1);
      end else begin
        wait_clk(2);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic send_byte(logic [7:0] b, bit ack_on_last = 0);
    model_byte(b, ack_on_last);
    send_bits(b, 8, ack_on_last);
  endtask

  task automatic cs_fall();
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_rise();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge CLK);
    #1 ack = 1'b0;
    if (m_full) begin
      m_full = 0;
      m_ovr  = 0;
      m_addr = 0;
    end
    wait_clk(1);
  endtask

  task automatic check_flags(string name);
    wait_clk(4);
    check({name, "_ready"}, ready, m_full);
    check({name, "_overrun"}, ovr, m_ovr);
    check({name, "_waddr"}, waddr, m_addr);
  endtask

  task automatic do_reset();
    check("pending_before_reset", exp_q.size(), 0);
    RST = 1'b1;
    wait_clk(3);
    check("reset_outputs", {rx_byte, rx_dv, we, waddr, wdata, ready, ovr}, 0);
    RST = 1'b0;
    m_addr = 0;
    m_full = 0;
    m_ovr  = 0;
    wait_clk(2);
  endtask

  always @(negedge CLK) begin
    if (chk_ready_next) begin
      chk_ready_next = 0;
      check("ready_after_last", ready, 1);
    end
    if (!RST && (rx_dv || we)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: dv=%b we=%b byte=%h, expected no output", rx_dv, we, rx_byte);
      end else begin
        e = exp_q.pop_front();
        check("dv_byte_we", {rx_dv, rx_byte, we}, {1'b1, e.b, e.we});
        if (e.we) begin
          check("write_addr_data", {waddr, wdata}, {e.addr, 8'h00, e.b});
          if (e.addr == AW'(DEPTH - 1)) begin
            check("ready_during_last", ready, 0);
            chk_ready_next = 1;
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    ph = $urandom_range(50, 2);
    do_reset();

    // single byte
    cs_fall();
    send_byte(8'hA5);
    check_flags("single");
    cs_rise();

    // full frame, overrun, ack, first byte of new frame
    do_reset();
    cs_fall();
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom));
    check_flags("frame");
    send_byte(8'h11);
    check_flags("overrun");
    pulse_ack();
    check_flags("ack");
    send_byte(8'h22);
    check_flags("after_ack");
    cs_rise();

    // aborted byte
    do_reset();
    cs_fall();
    send_bits(8'($urandom), 5, 0);
    cs_rise();
    cs_fall();
    send_byte(8'h3C);
    check_flags("abort");
    cs_rise();

    // reset mid-transfer with CS_n held low
    cs_fall();
    send_bits(8'($urandom), 4, 0);
    do_reset();
    send_bits(8'($urandom), 8, 0);
    check_flags("post_reset_ignore");
    cs_rise();
    cs_fall();
    send_byte(8'h5A);
    check_flags("post_reset");
    for (int i = 1; i < DEPTH; i++) send_byte(8'($urandom));
    check_flags("frame2");

    // ack coincident with byte completion
    send_byte(8'h77, 1);
    check_flags("simul_ack");
    cs_rise();

    // randomized traffic
    ph = $urandom_range(50, 2);
    cs_fall();
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(9))
        0: begin
          cs_rise();
          cs_fall();
        end
        1: pulse_ack();
        2: begin
          send_bits(8'($urandom), int'($urandom_range(7, 1)), 0);
          cs_rise();
          cs_fall();
        end
        default: send_byte(8'($urandom));
      endcase
      check_flags("random");
    end
    cs_rise();

    wait_clk(10);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_sample_rx.md
# spi_sample_rx

SPI slave receiver that deserializes mode-0 bytes arriving on SCLK/MOSI/CS_n and writes them as zero-extended 16-bit words into a sample RAM. It is the receiving end of the byte stream produced by the SPI master link in the FFT stage. Successive bytes fill a DEPTH-word frame buffer, and the FFT side is handed the buffer through a ready/ack handshake. All logic runs on the single system clock; SPI inputs are treated as asynchronous.

## Interface
- DEPTH, 32: frame length in bytes/words; power of two; sets o_WADDR width to log2(DEPTH).
- CLK  in  1  system clock, 16 MHz.
- RST  in  1  synchronous, active-high reset.
- i_SPI_Clk  in  1  SPI clock from master, asynchronous, idle low (mode 0).
- i_SPI_MOSI  in  1  serial data, MSB first, asynchronous.
- i_SPI_CS_n  in  1  chip select, active low, asynchronous.
- i_Frame_Ack  in  1  one-cycle pulse: consumer has taken the frame.
- o_RX_Byte  out  8  last completed byte; held until the next byte completes.
- o_RX_DV  out  1  one-cycle pulse per completed byte.
- o_WE  out  1  RAM write enable, one-cycle pulse.
- o_WADDR  out  log2(DEPTH)  RAM write address.
- o_WDATA  out  16  RAM write data, {8'h00, byte}.
- o_Frame_Ready  out  1  level: buffer holds DEPTH new words.
- o_Overrun  out  1  sticky: a byte arrived while o_Frame_Ready was high.

## Operation
- i_SPI_Clk, i_SPI_MOSI and i_SPI_CS_n each pass through a 2-FF synchronizer.
- A third register on synchronized SCLK detects rising edges. MOSI is taken from its synchronized stage on the detected edge.
- State machine:
  - IDLE → SHIFT: synchronized CS_n falls.
  - SHIFT → IDLE: synchronized CS_n rises.
  - SHIFT → FULL: the write to address DEPTH-1 occurs.
  - FULL → IDLE or SHIFT (per current CS_n): i_Frame_Ack.
- SHIFT:
  - Each SCLK rising edge shifts MOSI into an 8-bit register, MSB first, and increments a 3-bit bit counter.
  - On the 8th bit: o_RX_Byte updates, o_RX_DV=1, o_WE=1, o_WDATA={8'h00,byte}, o_WADDR=current address.
  - The address increments in the following cycle and wraps DEPTH-1 → 0.
- CS_n rising mid-byte: partial bits are discarded and the bit counter is cleared. The address is unchanged, so the next full byte goes to the next address.
- FULL:
  - o_Frame_Ready=1.
  - Completed bytes still update o_RX_Byte and pulse o_RX_DV, but o_WE stays 0 and o_Overrun sets.
  - i_Frame_Ack clears o_Frame_Ready and o_Overrun and resets the address to 0.
- i_Frame_Ack outside FULL has no effect.
- Ack and byte completion in the same cycle while in FULL: the ack takes effect and the byte is written to address 0 (o_WE=1). The address becomes 1 and o_Overrun stays 0.
- Reset:
  - All outputs go to 0, the address and bit counter to 0, and the state to IDLE.
  - Synchronizers reset to SCLK=0, CS_n=1.
  - If CS_n is low when RST is released, no bits are accepted until CS_n has gone high and fallen again.

## Timing
- SCLK frequency ≤ CLK/4 (4 MHz at 16 MHz). SCLK high and low each ≥ 2 CLK periods.
- MOSI must be stable from 2 CLK before to 2 CLK after each SCLK rising edge.
- CS_n falling to first SCLK rise: ≥ 3 CLK. Last SCLK fall to CS_n rising: ≥ 3 CLK.
- Latency from the 8th SCLK rising edge at the pin to o_RX_DV/o_WE high: 3 or 4 CLK cycles, depending on sampling phase.
- o_WE, o_RX_DV, o_WADDR and o_WDATA are registered and valid in the same cycle.
- o_Frame_Ready rises the cycle after the last frame write.
- o_Frame_Ready and o_Overrun fall the cycle after i_Frame_Ack is sampled.
- Back-to-back bytes (CS_n held low) need no gap; each byte is written independently.

## Test plan
- Single byte: reset, CS_n low, send 8'hA5 at 4 MHz → one o_RX_DV with o_RX_Byte=8'hA5, o_WE with o_WADDR=0 and o_WDATA=16'h00A5, address 1 afterwards, o_Frame_Ready=0.
- Full frame: send the 32 sine-table bytes 7F,7C,75,…,84 in one CS_n window → 32 writes to addresses 0..31 with matching data; o_Frame_Ready=1 one cycle after the 32nd write.
- Overrun and ack: after the full frame send 8'h11 → o_RX_DV pulse, no o_WE, o_Overrun=1. Then pulse i_Frame_Ack → both flags 0; send 8'h22 → write to address 0.
- Aborted byte: send 5 bits, raise CS_n, lower it again, send 8'h3C → exactly one o_RX_DV with 8'h3C, written at address 0.
- Reset mid-transfer: assert RST after 4 bits with CS_n still low, release, clock 8 more bits → no o_RX_DV. Raise and lower CS_n, send 8'h5A → written at address 0.
- Simultaneous ack: in FULL, align i_Frame_Ack with byte completion of 8'h77 → o_WE at address 0 with 16'h0077, o_Overrun stays 0.
